video_outmux_pipe: RTL and testbench

//  Parametrised final video output stage. Selects one of NSRC colour/hsync sources and registers its colour and syncs

---
 rtl/video_outmux_pipe_if.sv | 34 +++
 rtl/video_outmux_pipe.sv | 147 ++++++++++++++
 tb/tb_video_outmux_pipe.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/video_outmux_pipe_if.sv
// Bus bundle for the video output mux: per-source colour/hsync, common vsync,
// selection and pin polarity in; DAC colour, sync pins and status out.
interface video_outmux_pipe_if #(
  parameter int CW   = 2,
  parameter int NSRC = 2
);
  localparam int SW = (NSRC > 1) ? $clog2(NSRC) : 1;

  logic [NSRC*3*CW-1:0] src_color;
  logic [NSRC-1:0]      src_hsync;
  logic                 vsync;
  logic [SW-1:0]        sel_req;
  logic                 hpol;
  logic                 vpol;

  logic [CW-1:0]        vred;
  logic [CW-1:0]        vgrn;
  logic [CW-1:0]        vblu;
  logic                 vhsync;
  logic                 vvsync;
  logic                 vcsync;
  logic [SW-1:0]        sel_cur;
  logic                 busy;

  modport master (
    output src_color, src_hsync, vsync, sel_req, hpol, vpol,
    input  vred, vgrn, vblu, vhsync, vvsync, vcsync, sel_cur, busy
  );

  modport slave (
    input  src_color, src_hsync, vsync, sel_req, hpol, vpol,
    output vred, vgrn, vblu, vhsync, vvsync, vcsync, sel_cur, busy
  );
endinterface

// File: rtl/video_outmux_pipe.sv
// Final video output stage: frame-synchronous source select, post-switch black mute and an
// aligned colour/sync output pipeline. Optional composite sync via VIDEO_OUTMUX_CSYNC_EN.
module video_outmux_pipe #(
  parameter int CW      = 2,
  parameter int NSRC    = 2,
  parameter int PIPE    = 1,
  parameter int MUTE_LN = 4
) (
  input logic                clk,
  input logic                rst_n,
  video_outmux_pipe_if.slave vif
);
  localparam int SW   = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam int CBW  = 3 * CW;
  localparam int LAST = PIPE - 1;

  typedef enum logic [1:0] {RUN, PEND, MUTE} state_t;

  state_t        state, state_nx;
  logic [SW-1:0] sel_cur, sel_nx;
  logic [SW-1:0] tgt, tgt_nx;
  logic [7:0]    mcnt, mcnt_nx;
  logic          busy;
  logic          vsync_q;
  logic          hs_q;

  logic [CBW-1:0] col_cur;
  logic           hs_cur;
  logic           vs_rise;
  logic           hs_rise;
  logic           req_ok;
  logic           mute;

  logic [CBW-1:0] col_p [PIPE];
  logic [PIPE-1:0] hs_p;
  logic [PIPE-1:0] vs_p;

  // Source mux driven by the committed selection only, never by the raw request
  always_comb begin
    col_cur = '0;
    hs_cur  = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      if (sel_cur == SW'(k)) begin
        col_cur = vif.src_color[k*CBW +: CBW];
        hs_cur  = vif.src_hsync[k];
      end
    end
  end

  assign vs_rise = vif.vsync & ~vsync_q;
  assign hs_rise = hs_cur & ~hs_q;
  assign req_ok  = (int'(vif.sel_req) < NSRC);
  assign mute    = (state == MUTE);

  // Next-state logic; cancel takes priority over a coincident vsync edge
  always_comb begin
    state_nx = state;
    sel_nx   = sel_cur;
    tgt_nx   = tgt;
    mcnt_nx  = mcnt;
    case (state)
      RUN: begin
        if (req_ok && (vif.sel_req != sel_cur)) begin
          state_nx = PEND;
          tgt_nx   = vif.sel_req;
        end
      end
      PEND: begin
        if (vif.sel_req == sel_cur) begin
          state_nx = RUN;
        end else begin
          if (req_ok && (vif.sel_req != tgt)) begin
            tgt_nx = vif.sel_req;
          end
          if (vs_rise) begin
            sel_nx   = tgt_nx;
            mcnt_nx  = 8'(MUTE_LN);
            state_nx = (MUTE_LN == 0) ? RUN : MUTE;
          end
        end
      end
      MUTE: begin
        if (mcnt == 8'd0) begin
          state_nx = RUN;
        end else if (hs_rise) begin
          mcnt_nx = mcnt - 8'd1;
        end
      end
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      sel_cur <= '0;
      tgt     <= '0;
      mcnt    <= '0;
      busy    <= 1'b0;
      vsync_q <= 1'b0;
      hs_q    <= 1'b0;
    end else begin
      state   <= state_nx;
      sel_cur <= sel_nx;
      tgt     <= tgt_nx;
      mcnt    <= mcnt_nx;
      busy    <= (state_nx != RUN);
      vsync_q <= vif.vsync;
      hs_q    <= hs_cur;
    end
  end

  // Colour and syncs travel through identical stages so they stay aligned at the pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE; i++) begin
        col_p[i] <= '0;
      end
      hs_p <= '0;
      vs_p <= '0;
    end else begin
      col_p[0] <= mute ? '0 : col_cur;
      hs_p[0]  <= hs_cur;
      vs_p[0]  <= vif.vsync;
      for (int i = 1; i < PIPE; i++) begin
        col_p[i] <= col_p[i-1];
        hs_p[i]  <= hs_p[i-1];
        vs_p[i]  <= vs_p[i-1];
      end
    end
  end

  assign vif.vgrn    = col_p[LAST][3*CW-1 -: CW];
  assign vif.vred    = col_p[LAST][2*CW-1 -: CW];
  assign vif.vblu    = col_p[LAST][CW-1:0];
  assign vif.vhsync  = hs_p[LAST] ^ vif.hpol;
  assign vif.vvsync  = vs_p[LAST] ^ vif.vpol;
  assign vif.sel_cur = sel_cur;
  assign vif.busy    = busy;

`ifdef VIDEO_OUTMUX_CSYNC_EN
  assign vif.vcsync = ~(hs_p[LAST] ^ vs_p[LAST]);
`else
  assign vif.vcsync = 1'b1;
`endif

endmodule

// File: tb/tb_video_outmux_pipe.sv
// Scoreboard bench for video_outmux_pipe: expected pin values are queued when inputs are
// driven and compared PIPE clocks later, plus directed checks on selection, mute and reset.
module tb_video_outmux_pipe;
  localparam int CW      = 2;
  localparam int NSRC    = 3;
  localparam int PIPE    = 3;
  localparam int MUTE_LN = 4;
`ifdef VIDEO_OUTMUX_CSYNC_EN
  localparam bit CSYNC = 1'b1;
`else
  localparam bit CSYNC = 1'b0;
`endif

  typedef struct packed {
    logic [5:0] col;
    logic       hs;
    logic       vs;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  int         m_state;
  logic [1:0] m_sel;
  logic [1:0] m_tgt;
  int         m_mcnt;
  logic       m_vsq;
  logic       m_hsq;

  video_outmux_pipe_if #(.CW(CW), .NSRC(NSRC)) vif ();

  video_outmux_pipe #(
    .CW(CW), .NSRC(NSRC), .PIPE(PIPE), .MUTE_LN(MUTE_LN)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .vif   (vif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic modelReset();
    m_state = 0;
    m_sel   = 2'd0;
    m_tgt   = 2'd0;
    m_mcnt  = 0;
    m_vsq   = 1'b0;
    m_hsq   = 1'b0;
    sb_q.delete();
  endtask

  // One clock: predict the stage-0 capture from the current inputs, then compare after the edge
  task automatic applyStimulus();
    exp_t e;
    logic hs, vsr, hsr;
    logic [1:0] req;
    hs  = vif.src_hsync[int'(m_sel)];
    vsr = vif.vsync && !m_vsq;
    hsr = hs && !m_hsq;
    e.col = (m_state == 2) ? 6'h00 : vif.src_color[int'(m_sel)*6 +: 6];
    e.hs  = hs;
    e.vs  = vif.vsync;
    sb_q.push_back(e);
    req = vif.sel_req;
    if (m_state == 0) begin
      if (int'(req) < NSRC && req != m_sel) begin
        m_state = 1;
        m_tgt   = req;
      end
    end else if (m_state == 1) begin
      if (req == m_sel) begin
        m_state = 0;
      end else begin
        if (int'(req) < NSRC && req != m_tgt) m_tgt = req;
        if (vsr) begin
          m_sel   = m_tgt;
          m_mcnt  = MUTE_LN;
          m_state = (MUTE_LN == 0) ? 0 : 2;
        end
      end
    end else begin
      if (m_mcnt == 0) m_state = 0;
      else if (hsr) m_mcnt--;
    end
    m_vsq = vif.vsync;
    m_hsq = hs;

    @(posedge clk);
    #1;
    if (sb_q.size() == PIPE) begin
      e = sb_q.pop_front();
      checkOutput("sb_color", 32'({vif.vgrn, vif.vred, vif.vblu}), 32'(e.col));
      checkOutput("sb_vhsync", 32'(vif.vhsync), 32'(e.hs ^ vif.hpol));
      checkOutput("sb_vvsync", 32'(vif.vvsync), 32'(e.vs ^ vif.vpol));
      checkOutput("sb_vcsync", 32'(vif.vcsync), 32'(CSYNC ? ~(e.hs ^ e.vs) : 1'b1));
    end
    checkOutput("sb_sel_cur", 32'(vif.sel_cur), 32'(m_sel));
    checkOutput("sb_busy", 32'(vif.busy), 32'(m_state != 0));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  task automatic hpulse(input logic [2:0] mask, input int hi, input int lo);
    vif.src_hsync = mask;
    idle(hi);
    vif.src_hsync = 3'b000;
    idle(lo);
  endtask

  task automatic setColor(input int k, input logic [5:0] v);
    vif.src_color[k*6 +: 6] = v;
  endtask

  initial begin
    rst_n         = 1'b0;
    vif.src_color = '0;
    vif.src_hsync = '0;
    vif.vsync     = 1'b0;
    vif.sel_req   = '0;
    vif.hpol      = 1'b0;
    vif.vpol      = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_color", 32'({vif.vgrn, vif.vred, vif.vblu}), 32'h0);
    checkOutput("rst_vhsync", 32'(vif.vhsync), 32'h0);
    checkOutput("rst_vvsync", 32'(vif.vvsync), 32'h0);
    checkOutput("rst_vcsync", 32'(vif.vcsync), 32'h1);
    checkOutput("rst_sel_cur", 32'(vif.sel_cur), 32'h0);
    checkOutput("rst_busy", 32'(vif.busy), 32'h0);
    #2 rst_n = 1'b1;

    setColor(0, 6'h2A);
    setColor(1, 6'h1B);
    setColor(2, 6'h35);

    // Latency and skew: colour, hsync and vsync reach the pins after exactly PIPE clocks
    vif.src_hsync = 3'b001;
    vif.vsync     = 1'b1;
    applyStimulus();
    vif.src_hsync = 3'b000;
    vif.vsync     = 1'b0;
    applyStimulus();
    checkOutput("lat_early_color", 32'({vif.vgrn, vif.vred, vif.vblu}), 32'h0);
    checkOutput("lat_early_vhsync", 32'(vif.vhsync), 32'h0);
    applyStimulus();
    checkOutput("lat_vgrn", 32'(vif.vgrn), 32'h2);
    checkOutput("lat_vred", 32'(vif.vred), 32'h2);
    checkOutput("lat_vblu", 32'(vif.vblu), 32'h2);
    checkOutput("lat_vhsync", 32'(vif.vhsync), 32'h1);
    checkOutput("lat_vvsync", 32'(vif.vvsync), 32'h1);
    applyStimulus();
    checkOutput("lat_vhsync_end", 32'(vif.vhsync), 32'h0);

    // Composite sync: hs=1,vs=0 then hs=vs=1
    vif.src_hsync = 3'b001;
    applyStimulus();
    vif.vsync = 1'b1;
    applyStimulus();
    vif.src_hsync = 3'b000;
    vif.vsync     = 1'b0;
    applyStimulus();
    checkOutput("csync_hs1vs0", 32'(vif.vcsync), 32'(CSYNC ? 1'b0 : 1'b1));
    applyStimulus();
    checkOutput("csync_hs1vs1", 32'(vif.vcsync), 32'h1);
    idle(4);

    // Frame-synchronous switch to source 1 followed by a four-line mute
    vif.sel_req = 2'd1;
    applyStimulus();
    checkOutput("sw_busy_pend", 32'(vif.busy), 32'h1);
    checkOutput("sw_sel_hold", 32'(vif.sel_cur), 32'h0);
    hpulse(3'b001, 2, 4);
    checkOutput("sw_sel_hold2", 32'(vif.sel_cur), 32'h0);
    vif.vsync = 1'b1;
    applyStimulus();
    vif.vsync = 1'b0;
    checkOutput("sw_sel_new", 32'(vif.sel_cur), 32'h1);
    hpulse(3'b001, 2, 4);
    checkOutput("mute_black", 32'({vif.vgrn, vif.vred, vif.vblu}), 32'h0);
    repeat (3) hpulse(3'b010, 2, 4);
    checkOutput("mute_busy_3", 32'(vif.busy), 32'h1);
    checkOutput("mute_black_3", 32'({vif.vgrn, vif.vred, vif.vblu}), 32'h0);
    hpulse(3'b010, 2, 4);
    checkOutput("mute_busy_done", 32'(vif.busy), 32'h0);
    idle(3);
    checkOutput("src1_color", 32'({vif.vgrn, vif.vred, vif.vblu}), 32'h1B);

    // Cancelled request: no switch, busy drops one clock after the request reverts
    vif.sel_req = 2'd2;
    applyStimulus();
    checkOutput("cancel_busy_on", 32'(vif.busy), 32'h1);
    vif.sel_req = 2'd1;
    applyStimulus();
    checkOutput("cancel_busy_off", 32'(vif.busy), 32'h0);
    vif.vsync = 1'b1;
    applyStimulus();
    vif.vsync = 1'b0;
    idle(2);
    checkOutput("cancel_sel", 32'(vif.sel_cur), 32'h1);

    // Out-of-range request is ignored; inverted pin polarity
    vif.sel_req = 2'd3;
    idle(3);
    checkOutput("oor_busy", 32'(vif.busy), 32'h0);
    checkOutput("oor_sel", 32'(vif.sel_cur), 32'h1);
    vif.hpol = 1'b1;
    vif.vpol = 1'b1;
    idle(4);
    checkOutput("pol_vhsync", 32'(vif.vhsync), 32'h1);
    checkOutput("pol_vvsync", 32'(vif.vvsync), 32'h1);
    hpulse(3'b010, 1, 3);
    vif.hpol = 1'b0;
    vif.vpol = 1'b0;

    // Retarget with vsync edge in the same cycle; request change during mute does not abort it
    vif.sel_req = 2'd0;
    applyStimulus();
    vif.sel_req = 2'd2;
    vif.vsync   = 1'b1;
    applyStimulus();
    vif.vsync = 1'b0;
    checkOutput("retarget_sel", 32'(vif.sel_cur), 32'h2);
    repeat (2) hpulse(3'b100, 2, 3);
    vif.sel_req = 2'd1;
    hpulse(3'b100, 2, 3);
    checkOutput("mute_no_abort_busy", 32'(vif.busy), 32'h1);
    checkOutput("mute_no_abort_sel", 32'(vif.sel_cur), 32'h2);
    hpulse(3'b100, 2, 3);
    checkOutput("post_mute_pend_busy", 32'(vif.busy), 32'h1);
    checkOutput("post_mute_pend_sel", 32'(vif.sel_cur), 32'h2);
    checkOutput("post_mute_color", 32'({vif.vgrn, vif.vred, vif.vblu}), 32'h35);

    // Asynchronous reset mid-PEND, between clock edges
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_color", 32'({vif.vgrn, vif.vred, vif.vblu}), 32'h0);
    checkOutput("arst_vcsync", 32'(vif.vcsync), 32'h1);
    checkOutput("arst_sel_cur", 32'(vif.sel_cur), 32'h0);
    checkOutput("arst_busy", 32'(vif.busy), 32'h0);
    modelReset();
    vif.sel_req = 2'd0;
    #2 rst_n = 1'b1;
    idle(5);
    checkOutput("arst_lost_sel", 32'(vif.sel_cur), 32'h0);
    checkOutput("arst_lost_busy", 32'(vif.busy), 32'h0);

    // Randomised traffic against the scoreboard
    for (int i = 0; i < 80; i++) begin
      vif.src_color = 18'($urandom);
      vif.src_hsync = 3'($urandom_range(0, 7));
      vif.vsync     = ($urandom_range(0, 7) == 0);
      vif.hpol      = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) vif.sel_req = 2'($urandom_range(0, 3));
      applyStimulus();
    end
    idle(PIPE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
